// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 op codes, FSM state encoding and the iteration count.
package muldiv_pkg;

  localparam int ITER_COUNT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // rs1 is treated as two's complement for these ops.
  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-divide iteration: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module muldiv_div_step
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0]   shifted;
  logic [W+1:0] diff;

  assign shifted = {rem_i, quo_i[W-1]};
  assign diff    = {1'b0, shifted} - {2'b00, divisor_i};

  always_comb begin
    if (diff[W+1]) begin
      rem_o = shifted[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end else begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed 33-edge latency.
// Define MULDIV_DIV_EN to include the divider; otherwise divide ops report illegal.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            write_enable,
  output logic            illegal
);

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d, rd_out_q, rd_out_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d, result_q, result_d;
  logic                neg_q, neg_d, illegal_q, illegal_d;
`ifdef MULDIV_DIV_EN
  logic                rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]     div_rem, div_quo;
`endif

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     fin_result;
  logic                fin_illegal;

  assign a_neg = rs1_signed(funct3) & rs1_data[XLEN-1];
  assign b_neg = rs2_signed(funct3) & rs2_data[XLEN-1];
  assign a_mag = a_neg ? -rs1_data : rs1_data;
  assign b_mag = b_neg ? -rs2_data : rs2_data;

  // acc holds {high, low}: multiplier bits shift out of low, product grows into high.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  muldiv_div_step #(.W(XLEN)) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .quo_i     (acc_q[XLEN-1:0]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );
`endif

  always_comb begin
    fin_result  = '0;
    fin_illegal = 1'b0;
    case (op_q)
      F3_MUL:                       fin_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fin_result = prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      // Divide by zero forces all-ones quotient regardless of sign.
      F3_DIV:  fin_result = (opnd_q == '0) ? '1 :
                            (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
      F3_DIVU: fin_result = acc_q[XLEN-1:0];
      F3_REM:  fin_result = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      F3_REMU: fin_result = acc_q[2*XLEN-1:XLEN];
      default: fin_result = '0;
`else
      default: fin_illegal = 1'b1;
`endif
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    illegal_d = illegal_q;
`ifdef MULDIV_DIV_EN
    rem_neg_d = rem_neg_q;
`endif
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_CALC;
            cnt_d   = '0;
            op_d    = funct3;
            rd_d    = rd_in;
            neg_d   = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
            rem_neg_d = a_neg;
`endif
            if (funct3[2]) begin
              acc_d  = {{XLEN{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{XLEN{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end
        end
        ST_CALC: begin
          if (cnt_q != 6'(ITER_COUNT)) begin
            cnt_d = cnt_q + 6'd1;
            if (!op_q[2]) acc_d = {mul_sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
            else          acc_d = {div_rem, div_quo};
`endif
          end else begin
            state_d   = ST_DONE;
            result_d  = fin_result;
            rd_out_d  = rd_q;
            illegal_d = fin_illegal;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
      illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
      illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign result       = result_q;
  assign rd_out       = rd_out_q;
  assign illegal      = done & illegal_q;
  assign write_enable = done & ~illegal_q & (rd_out_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, mul/div results, corner cases,
// start-while-busy, kill and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        write_enable;
  logic        illegal;

  int vectors    = 0;
  int miscompares = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .kill         (kill),
    .funct3       (funct3),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .rd_in        (rd_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .rd_out       (rd_out),
    .write_enable (write_enable),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for done (bounded), then check the result cycle and the cycle after.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic exp_we, input logic exp_ill);
    int lat;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    check({tag, " latency"}, 32'(lat), 32'd33);
    check({tag, " result"},  result, exp_res);
    check({tag, " rd_out"},  {27'd0, rd_out}, {27'd0, rd});
    check({tag, " we"},      {31'd0, write_enable}, {31'd0, exp_we});
    check({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    @(posedge clk); #1;
    check({tag, " done drop"}, {31'd0, done}, 32'd0);
    check({tag, " hold"},      result, exp_res);
  endtask

  int pulses;
  int lat2;
  logic [31:0] res2;
  logic [4:0]  rd2;

  initial begin
    reset = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = 3'd0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    #12;
    check("rst busy",    {31'd0, busy}, 32'd0);
    check("rst done",    {31'd0, done}, 32'd0);
    check("rst result",  result, 32'd0);
    check("rst rd_out",  {27'd0, rd_out}, 32'd0);
    check("rst we",      {31'd0, write_enable}, 32'd0);
    check("rst illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mul7x6",   3'b000, 32'd7,        32'd6,        5'd5,  32'd42,        1'b1, 1'b0);
    run_op("mulh",     3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000,  1'b1, 1'b0);
    run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE,  1'b1, 1'b0);
    run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF,  1'b1, 1'b0);
    run_op("mulneg",   3'b000, 32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFF1,  1'b1, 1'b0);
    run_op("mulx0",    3'b000, 32'd3,        32'd3,        5'd0,  32'd9,         1'b0, 1'b0);
`ifdef MULDIV_DIV_EN
    run_op("divovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000,  1'b1, 1'b0);
    run_op("removf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'd0,         1'b1, 1'b0);
    run_op("divu0",    3'b101, 32'd100,      32'd0,        5'd7,  32'hFFFFFFFF,  1'b1, 1'b0);
    run_op("remu0",    3'b111, 32'd100,      32'd0,        5'd7,  32'd100,       1'b1, 1'b0);
    run_op("div-7/2",  3'b100, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD,  1'b1, 1'b0);
    run_op("rem-7/2",  3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF,  1'b1, 1'b0);
    run_op("div0s",    3'b100, 32'hFFFFFFFB, 32'd0,        5'd9,  32'hFFFFFFFF,  1'b1, 1'b0);
    run_op("rem0s",    3'b110, 32'hFFFFFFFB, 32'd0,        5'd9,  32'hFFFFFFFB,  1'b1, 1'b0);
    run_op("divu9/3",  3'b101, 32'd9,        32'd3,        5'd10, 32'd3,         1'b1, 1'b0);
`else
    run_op("divu9/3",  3'b101, 32'd9,        32'd3,        5'd10, 32'd0,         1'b0, 1'b1);
    run_op("div-7/2",  3'b100, 32'hFFFFFFF9, 32'd2,        5'd8,  32'd0,         1'b0, 1'b1);
`endif
    run_op("mulhu16",  3'b011, 32'h00010000, 32'h00010000, 5'd11, 32'd1,         1'b1, 1'b0);

    // Second start five cycles into CALC must be ignored.
    @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd4; rd_in = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; lat2 = -1; res2 = '0; rd2 = '0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        pulses++; lat2 = i; res2 = result; rd2 = rd_out;
      end
      if (i == 5) begin
        funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd8; start = 1'b1;
      end
    end
    check("busy start pulses",  32'(pulses), 32'd1);
    check("busy start latency", 32'(lat2), 32'd33);
    check("busy start result",  res2, 32'd12);
    check("busy start rd_out",  {27'd0, rd2}, 32'd7);

    // Kill ten cycles into CALC.
    @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd5; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 11) begin
        kill = 1'b0;
        check("kill busy", {31'd0, busy}, 32'd0);
      end
      if (done || write_enable) pulses++;
      if (i == 10) kill = 1'b1;
    end
    check("kill no done", 32'(pulses), 32'd0);
    check("kill result held", result, 32'd12);

    // Asynchronous reset twenty cycles into CALC.
    @(negedge clk);
    funct3 = 3'b011; rs1_data = 32'hFFFFFFFF; rs2_data = 32'd7; rd_in = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("arst busy",   {31'd0, busy}, 32'd0);
    check("arst done",   {31'd0, done}, 32'd0);
    check("arst result", result, 32'd0);
    check("arst rd_out", {27'd0, rd_out}, 32'd0);
    check("arst we",     {31'd0, write_enable}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (done || write_enable) pulses++;
    end
    check("arst no done", 32'(pulses), 32'd0);

    run_op("post rst", 3'b000, 32'd11, 32'd13, 5'd31, 32'd143, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
